// File: rtl/fp_mul_pkg.sv
// Shared constants and stage-1 payload for the fp multiplier post-multiply stage.
package fp_mul_pkg;
  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int MANT_W   = 24;
  localparam int PROD_W   = 48;
  localparam int EXPSUM_W = 10;
  localparam int BIAS     = 127;
  localparam logic [7:0] EXP_INF = 8'hFF;

  // Internal exponent carries two spare bits so that the normalize and
  // rounding increments can never wrap, whatever the 10-bit input holds.
  localparam int EXPI_W = EXPSUM_W + 2;
  localparam logic signed [EXPI_W-1:0] EXP_MAX  = 255;
  localparam logic signed [EXPI_W-1:0] EXP_ZERO = 0;

  typedef struct packed {
    logic                     sign;
    logic                     zero;
    logic signed [EXPI_W-1:0] exp;
    logic [MANT_W-1:0]        sig;
    logic                     guard;
    logic                     sticky;
  } s1_t;
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized 24-bit significand.
module fp_round_rne
  import fp_mul_pkg::*;
(
  input  logic [MANT_W-1:0]        sig,
  input  logic                     guard,
  input  logic                     sticky,
  input  logic signed [EXPI_W-1:0] exp_in,
  output logic [FRAC_W-1:0]        frac,
  output logic signed [EXPI_W-1:0] exp_out
);
  logic [MANT_W:0] sig_r;
  logic            rnd_up;
  logic            unused_hidden;

  // Increment on guard when above half or on a tie with an odd lsb; a carry
  // out of the significand renormalizes to 1.0 with the next exponent.
  always_comb begin
    rnd_up        = guard & (sticky | sig[0]);
    sig_r         = {1'b0, sig} + {{MANT_W{1'b0}}, rnd_up};
    frac          = sig_r[MANT_W] ? '0 : sig_r[FRAC_W-1:0];
    exp_out       = exp_in + EXPI_W'(sig_r[MANT_W]);
    unused_hidden = sig_r[FRAC_W];
  end
endmodule

// File: rtl/fp_mul_normalize_round.sv
// Post-multiply stage: normalize (stage 1), round and pack binary32 (stage 2).
module fp_mul_normalize_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sign,
  input  logic [fp_mul_pkg::EXPSUM_W-1:0] in_exp,
  input  logic [fp_mul_pkg::PROD_W-1:0]   in_mant,
  input  logic                            in_zero,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [EXP_W+FRAC_W:0]           product,
  output logic                            overflow,
  output logic                            underflow,
  output logic                            inexact
);
  import fp_mul_pkg::*;

  logic adv, s1_fire;
  s1_t  s1_n, s1_d, s1_q;
  logic s1_valid_d, s1_valid_q, s2_valid_d, s2_valid_q;
  logic [EXP_W+FRAC_W:0] res_prod, product_d, product_q;
  logic res_ovf, res_unf, res_inx;
  logic ovf_d, ovf_q, unf_d, unf_q, inx_d, inx_q;
  logic [fp_mul_pkg::FRAC_W-1:0] rnd_frac;
  logic signed [EXPI_W-1:0]      rnd_exp;

  // Handshake: stage 1 moves forward whenever the output slot frees up.
  always_comb begin
    adv      = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || adv;
    s1_fire  = in_valid && in_ready;
  end

  // Normalize: product lies in [1,4); bit 47 selects the shift and bumps exp.
  always_comb begin
    s1_n      = '0;
    s1_n.sign = in_sign;
    s1_n.zero = in_zero;
    if (in_mant[PROD_W-1]) begin
      s1_n.sig    = in_mant[PROD_W-1 -: MANT_W];
      s1_n.guard  = in_mant[PROD_W-MANT_W-1];
      s1_n.sticky = |in_mant[PROD_W-MANT_W-2:0];
    end else begin
      s1_n.sig    = in_mant[PROD_W-2 -: MANT_W];
      s1_n.guard  = in_mant[PROD_W-MANT_W-2];
      s1_n.sticky = |in_mant[PROD_W-MANT_W-3:0];
    end
    s1_n.exp = {{(EXPI_W-EXPSUM_W){in_exp[EXPSUM_W-1]}}, in_exp}
             + EXPI_W'(in_mant[PROD_W-1]);
  end

  fp_round_rne u_rnd (
    .sig    (s1_q.sig),
    .guard  (s1_q.guard),
    .sticky (s1_q.sticky),
    .exp_in (s1_q.exp),
    .frac   (rnd_frac),
    .exp_out(rnd_exp)
  );

  // Result select; the range checks see the exponent after the rounding carry.
  always_comb begin
    res_prod = '0;
    res_ovf  = 1'b0;
    res_unf  = 1'b0;
    res_inx  = 1'b0;
    if (s1_q.zero) begin
      res_prod = {s1_q.sign, {(EXP_W+FRAC_W){1'b0}}};
    end else if (rnd_exp >= EXP_MAX) begin
      res_prod = {s1_q.sign, EXP_INF, {FRAC_W{1'b0}}};
      res_ovf  = 1'b1;
      res_inx  = 1'b1;
    end else if (rnd_exp <= EXP_ZERO) begin
      res_prod = {s1_q.sign, {(EXP_W+FRAC_W){1'b0}}};
      res_unf  = 1'b1;
      res_inx  = 1'b1;
    end else begin
      res_prod = {s1_q.sign, rnd_exp[EXP_W-1:0], rnd_frac};
      res_inx  = s1_q.guard | s1_q.sticky;
    end
  end

  // Next state: each stage loads when its consumer frees it, else holds.
  always_comb begin
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_d       = s1_fire ? s1_n : s1_q;
    s2_valid_d = adv ? s1_valid_q : s2_valid_q;
    product_d  = product_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    inx_d      = inx_q;
    if (adv && s1_valid_q) begin
      product_d = res_prod;
      ovf_d     = res_ovf;
      unf_d     = res_unf;
      inx_d     = res_inx;
    end
  end

  // Pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      product_q  <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      product_q  <= product_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      inx_q      <= inx_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign product   = product_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;
endmodule

// File: tb/tb_fp_mul_normalize_round.sv
// Bench for fp_mul_normalize_round: directed corner cases, backpressure,
// mid-stream reset and a randomized stream against an arithmetic model.
module tb_fp_mul_normalize_round;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic        in_sign = 1'b0, in_zero = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [47:0] in_mant = '0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] product;
  logic        overflow, underflow, inexact;

  fp_mul_normalize_round dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_zero(in_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] prod;
    logic        ov, un, ix;
    int          t;
  } item_t;

  item_t q[$];
  int    n_cmp = 0, n_err = 0, cyc = 0, n_out = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: value-level normalize and RNE using integer remainders.
  function automatic item_t model(input logic s, input logic [9:0] ex,
                                  input logic [47:0] m, input logic z);
    item_t  r;
    longint mm, sig, rem, half;
    int     e;
    logic [63:0] sv;
    logic [31:0] ev;
    r.prod = '0; r.ov = 0; r.un = 0; r.ix = 0; r.t = 0;
    if (z) begin
      r.prod = {s, 31'b0};
      return r;
    end
    mm = longint'(m);
    e  = int'($signed(ex));
    if (mm >= (64'sd1 <<< 47)) begin
      sig = mm >>> 24; rem = mm % (64'sd1 <<< 24); half = 64'sd1 <<< 23; e = e + 1;
    end else begin
      sig = mm >>> 23; rem = mm % (64'sd1 <<< 23); half = 64'sd1 <<< 22;
    end
    r.ix = (rem != 0);
    if (rem > half || (rem == half && (sig % 2) == 1)) sig = sig + 1;
    if (sig == (64'sd1 <<< 24)) begin
      sig = 64'sd1 <<< 23; e = e + 1;
    end
    sv = 64'(sig);
    ev = 32'(e);
    if (e >= 255) begin
      r.prod = {s, 8'hFF, 23'b0}; r.ov = 1; r.ix = 1;
    end else if (e <= 0) begin
      r.prod = {s, 31'b0}; r.un = 1; r.ix = 1;
    end else begin
      r.prod = {s, ev[7:0], sv[22:0]};
    end
    return r;
  endfunction

  // One clock: check handshake and outputs against the in-flight queue,
  // then advance the model by whatever transferred on the edge.
  task automatic tick();
    logic  exp_ir, exp_ov, fi, fo;
    item_t it;
    exp_ir = (q.size() < 2) || out_ready;
    exp_ov = (q.size() > 0) && (cyc >= q[0].t + 2);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, exp_ov);
    if (exp_ov && out_valid) begin
      chk("product", product, q[0].prod);
      chk("flags", {overflow, underflow, inexact}, {q[0].ov, q[0].un, q[0].ix});
    end
    fi = in_valid && exp_ir && !rst;
    fo = exp_ov && out_ready && !rst;
    it = model(in_sign, in_exp, in_mant, in_zero);
    @(posedge clk); #1;
    cyc++;
    if (rst) q.delete();
    else begin
      if (fo) begin void'(q.pop_front()); n_out++; end
      if (fi) begin it.t = cyc - 1; q.push_back(it); end
    end
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic directed(input string tag, input logic s, input int ex,
                          input logic [47:0] m, input logic z,
                          input logic [31:0] prod, input logic ov, un, ix);
    drain();
    in_valid = 1'b1; in_sign = s; in_exp = 10'(ex); in_mant = m; in_zero = z;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_lat"}, out_valid, 1'b1);
    chk(tag, product, prod);
    chk({tag, "_flags"}, {overflow, underflow, inexact}, {ov, un, ix});
    tick();
  endtask

  task automatic rand_item();
    logic [23:0] a, b;
    a = 24'h800000 | 24'($urandom);
    b = 24'h800000 | 24'($urandom);
    in_mant = 48'(a) * 48'(b);
    in_exp  = 10'($urandom_range(0, 340) - 40);
    in_sign = 1'($urandom);
    in_zero = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int   sent, base;
    logic blocked, held;

    // Reset
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; cyc++; end
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_product", product, 32'h0);
    chk("rst_flags", {overflow, underflow, inexact}, 3'b000);

    // Directed corner cases
    directed("mul_1p5", 0, 127, 48'h900000000000, 0, 32'h40100000, 0, 0, 0);
    directed("tie_even", 0, 127, 48'h400000400000, 0, 32'h3F800000, 0, 0, 1);
    directed("tie_odd", 0, 127, 48'h400000C00000, 0, 32'h3F800002, 0, 0, 1);
    directed("rnd_carry", 0, 127, 48'h7FFFFFC00000, 0, 32'h40000000, 0, 0, 1);
    directed("carry_ovf", 0, 254, 48'h7FFFFFC00000, 0, 32'h7F800000, 1, 0, 1);
    directed("exp_ovf", 0, 254, 48'h800000000000, 0, 32'h7F800000, 1, 0, 1);
    directed("exp_unf", 1, 0, 48'h400000000000, 0, 32'h80000000, 0, 1, 1);
    directed("zero_neg", 1, 127, 48'h900000000000, 1, 32'h80000000, 0, 0, 0);

    // Backpressure: 6 back-to-back items, out_ready low for cycles 3..6
    drain();
    sent = 0; blocked = 0; held = 0; base = n_out;
    for (int i = 0; i < 14; i++) begin
      out_ready = !(i >= 3 && i <= 6);
      if (sent < 6) begin
        if (!held) rand_item();
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #0;
      if (in_valid && !in_ready) blocked = 1;
      held = in_valid && !in_ready;
      if (in_valid && in_ready) sent++;
      tick();
    end
    drain();
    chk("bp_in_ready_dropped", blocked, 1'b1);
    chk("bp_out_count", 64'(n_out - base), 64'd6);

    // Reset with two items in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_item(); tick();
    rand_item(); tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_product", product, 32'h0);
    base = n_out;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("mid_rst_no_ghosts", 64'(n_out - base), 64'd0);

    // Randomized stream with random backpressure
    held = 0;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (!held) begin
        in_valid = ($urandom_range(0, 3) != 0);
        if (in_valid) rand_item();
      end
      #0;
      held = in_valid && !in_ready;
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fp_mul_normalize_round.md
Name: fp_mul_normalize_round

Overview:
Post-multiply stage of the single-precision floating-point multiplier datapath.
- Consumes the raw 48-bit mantissa product, biased exponent sum and result sign from the exponent-add / mantissa-multiply stage.
- Normalizes, rounds to nearest-even and packs an IEEE-754 binary32 result with status flags.
- Two-stage pipeline with a valid/ready handshake on both sides.

Parameters:
EXP_W, 8, exponent field width (only 8 supported/verified)
FRAC_W, 23, fraction field width (only 23 supported/verified)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream presents a product this cycle
in_ready  output  1  stage can accept input this cycle
in_sign  input  1  sign_a XOR sign_b
in_exp  input  10  signed two's-complement biased exponent sum, exp_a + exp_b - 127
in_mant  input  48  unsigned 24x24 product of {1,frac_a} and {1,frac_b}
in_zero  input  1  either operand was zero; forces a signed-zero result
out_valid  output  1  product/flags valid
out_ready  input  1  downstream accepts this cycle
product  output  32  packed binary32 result
overflow  output  1  result saturated to infinity
underflow  output  1  result flushed to zero
inexact  output  1  rounding or flush discarded nonzero bits

Behaviour:
- Transfer rule: a transfer occurs on a cycle with valid && ready, on either side.
- Reset: s1_valid = s2_valid = 0, so out_valid = 0. product, overflow, underflow and inexact reset to 0. in_ready is 1 the cycle after reset.
- Reset mid-operation discards all in-flight items with no output.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 per cycle.
- Backpressure:
  - Output registers hold stable while out_valid && !out_ready.
  - Stage 1 advances when !s2_valid || out_ready.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - No item is dropped, duplicated or reordered.
- Stage 1 (normalize), registered:
  - If in_mant[47] = 1: sig = mant[47:24], guard = mant[46-23] = mant[23], sticky = |mant[22:0], exp = in_exp + 1.
  - Else: sig = mant[46:23], guard = mant[22], sticky = |mant[21:0], exp = in_exp.
  - Sign and zero flag pass through.
- Stage 2 (round/pack), registered:
  - Round-to-nearest-even: round up when guard && (sticky || sig[0]).
  - Compute sig_r as a 25-bit value. If sig_r[24] = 1 (carry out), the fraction becomes 0 and exp is incremented by 1.
- Stage 2 result select, in priority order:
  1. zero flag: product = {sign, 31'b0}; all flags 0.
  2. exp >= 255: product = {sign, 8'hFF, 23'b0}; overflow = 1; inexact = 1.
  3. exp <= 0: flush to zero, no denormals. product = {sign, 31'b0}; underflow = 1; inexact = 1.
  4. Otherwise: product = {sign, exp[7:0], sig_r[22:0]}; inexact = guard | sticky.
- The exponent overflow check is applied after the rounding carry. Example: exp 254 with a rounding carry overflows.
- NaN/Inf inputs are screened upstream and are out of scope for this stage.
- Flags are valid only while out_valid = 1.

Decomposition:
- Shared package fp_mul_pkg holds:
  - constants BIAS = 127, EXP_INF = 8'hFF, EXP_W, FRAC_W, MANT_W = 24, PROD_W = 48, EXPSUM_W = 10;
  - a struct for the stage-1 payload {sign, zero, exp, sig, guard, sticky}.
- One sub-module, fp_round_rne: combinational. Takes sig, guard, sticky and exp; produces the rounded fraction and adjusted exp.
- Pipeline registers and handshake stay in the top module.

Test Plan:
- 1.5*1.5: in_mant = 48'h900000000000, in_exp = 127, sign 0 -> product 32'h40100000, all flags 0, out_valid exactly 2 cycles after input.
- Tie cases:
  - mant = 48'h400000400000, exp 127 (guard 1, sticky 0, lsb 0) -> 32'h3F800000, inexact 1 (rounds down to even).
  - mant = 48'h400000C00000 (lsb 1) -> 32'h3F800002, inexact 1.
- Rounding carry: mant = 48'h7FFFFFC00000, exp 127 -> 32'h40000000, inexact 1. Same mant with exp 254 -> 32'h7F800000, overflow 1.
- Boundary exponents:
  - exp 254, mant = 48'h800000000000 -> 32'h7F800000, overflow 1.
  - exp 0, mant = 48'h400000000000, sign 1 -> 32'h80000000, underflow 1.
  - in_zero 1 with sign 1 -> 32'h80000000, no flags.
- Backpressure: stream 6 back-to-back items with out_ready low for cycles 3-6. in_ready drops when both stages are full; the outputs appear in order with no loss and product is held stable while stalled.
- Reset mid-stream: assert rst with 2 items in flight -> out_valid 0 the next cycle, the in-flight items never appear, and in_ready = 1 after rst deasserts.
